// File: rtl/mvu_inp_buf.sv
// Activation-side feeder for the MVU PE array. It stores one input vector of SF words
// and presents it NF times on in_act, flagging the last word of each pass and the last pass.
module mvu_inp_buf #(
  parameter int SIMD    = 2,
  parameter int PE      = 2,
  parameter int MatrixW = 8,
  parameter int MatrixH = 4,
  parameter int TSrcI   = 1,
  parameter int TI      = SIMD * TSrcI
) (
  input  logic          rst_n,
  input  logic          clk,
  input  logic          in_v,
  output logic          in_rdy,
  input  logic [TI-1:0] in,
  input  logic          out_rdy,
  output logic          out_v,
  output logic [TI-1:0] out,
  output logic          out_sf_last,
  output logic          out_nf_last
);

  localparam int SF  = MatrixW / SIMD;
  localparam int NF  = MatrixH / PE;
  localparam int SFW = (SF > 1) ? $clog2(SF) : 1;
  localparam int NFW = (NF > 1) ? $clog2(NF) : 1;

  localparam logic [SFW-1:0] SF_LAST = SFW'(SF - 1);
  localparam logic [NFW-1:0] NF_LAST = NFW'(NF - 1);
  localparam logic           NF_ONE  = (NF == 1);

  typedef enum logic {
    WRITE,
    READ
  } state_e;

  state_e         state_q, state_d;
  logic [SFW-1:0] sf_q, sf_d;
  logic [NFW-1:0] nf_q, nf_d;
  logic           out_v_q, out_v_d;
  logic [TI-1:0]  out_q, out_d;
  logic           sf_last_q, sf_last_d;
  logic           nf_last_q, nf_last_d;
  logic [TI-1:0]  mem_q [SF];
  logic           mem_we;
  logic           adv;

  always_comb begin
    adv       = !out_v_q || out_rdy;
    state_d   = state_q;
    sf_d      = sf_q;
    nf_d      = nf_q;
    out_v_d   = out_v_q;
    out_d     = out_q;
    sf_last_d = sf_last_q;
    nf_last_d = nf_last_q;
    mem_we    = 1'b0;
    in_rdy    = 1'b0;

    case (state_q)
      WRITE: begin
        // First pass forwards the accepted word directly while capturing it.
        in_rdy = adv;
        if (adv) begin
          if (in_v) begin
            mem_we    = 1'b1;
            out_d     = in;
            out_v_d   = 1'b1;
            sf_last_d = (sf_q == SF_LAST);
            nf_last_d = NF_ONE;
            if (sf_q == SF_LAST) begin
              sf_d = '0;
              if (!NF_ONE) begin
                nf_d    = NFW'(1);
                state_d = READ;
              end
            end else begin
              sf_d = sf_q + SFW'(1);
            end
          end else begin
            out_v_d = 1'b0;
          end
        end
      end

      READ: begin
        if (adv) begin
          out_d     = mem_q[sf_q];
          out_v_d   = 1'b1;
          sf_last_d = (sf_q == SF_LAST);
          nf_last_d = (nf_q == NF_LAST);
          if (sf_q == SF_LAST) begin
            sf_d = '0;
            if (nf_q == NF_LAST) begin
              nf_d    = '0;
              state_d = WRITE;
            end else begin
              nf_d = nf_q + NFW'(1);
            end
          end else begin
            sf_d = sf_q + SFW'(1);
          end
        end
      end

      default: state_d = WRITE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WRITE;
      sf_q      <= '0;
      nf_q      <= '0;
      out_v_q   <= 1'b0;
      out_q     <= '0;
      sf_last_q <= 1'b0;
      nf_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sf_q      <= sf_d;
      nf_q      <= nf_d;
      out_v_q   <= out_v_d;
      out_q     <= out_d;
      sf_last_q <= sf_last_d;
      nf_last_q <= nf_last_d;
    end
  end

  // Vector storage carries no reset; its contents are only read after being written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[sf_q] <= in;
    end
  end

  assign out_v       = out_v_q;
  assign out         = out_q;
  assign out_sf_last = sf_last_q;
  assign out_nf_last = nf_last_q;

endmodule

// File: tb/tb_mvu_inp_buf.sv
// Self-checking bench for mvu_inp_buf: a directed vector table, hand-written corner sequences,
// and randomized handshakes checked against a queue-based model of the replay stream.
module tb_mvu_inp_buf;

  // Main instance: 8-bit words, SF=4, NF=2 (wide enough for the 0xA..0xF words).
  localparam int TI = 8;
  localparam int SF = 4;
  localparam int NF = 2;

  logic          clk;
  logic          rst_n;
  logic          in_v, in_rdy, out_rdy, out_v, out_sf_last, out_nf_last;
  logic [TI-1:0] in, out;

  // Degenerate instance: SF=1, NF=1, 2-bit words.
  logic          in_v1, in_rdy1, out_rdy1, out_v1, out_sf_last1, out_nf_last1;
  logic [1:0]    in1, out1;

  mvu_inp_buf #(
    .SIMD(4), .PE(2), .MatrixW(16), .MatrixH(4), .TSrcI(2)
  ) u_dut (
    .rst_n(rst_n), .clk(clk), .in_v(in_v), .in_rdy(in_rdy), .in(in),
    .out_rdy(out_rdy), .out_v(out_v), .out(out),
    .out_sf_last(out_sf_last), .out_nf_last(out_nf_last)
  );

  mvu_inp_buf #(
    .SIMD(2), .PE(2), .MatrixW(2), .MatrixH(2), .TSrcI(1)
  ) u_dut1 (
    .rst_n(rst_n), .clk(clk), .in_v(in_v1), .in_rdy(in_rdy1), .in(in1),
    .out_rdy(out_rdy1), .out_v(out_v1), .out(out1),
    .out_sf_last(out_sf_last1), .out_nf_last(out_nf_last1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    in_v     = 1'b0;
    in       = '0;
    out_rdy  = 1'b0;
    in_v1    = 1'b0;
    in1      = '0;
    out_rdy1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic          iv;
    logic [TI-1:0] d;
    logic          ordy;
    logic          e_irdy;
    logic          e_ov;
    logic [TI-1:0] e_out;
    logic          e_sl;
    logic          e_nl;
  } vec_t;

  function automatic vec_t mk(input logic [TI-1:0] d, input logic irdy, input logic ov,
                              input logic [TI-1:0] o, input logic sl, input logic nl);
    vec_t v;
    v.iv = 1'b1; v.d = d; v.ordy = 1'b1;
    v.e_irdy = irdy; v.e_ov = ov; v.e_out = o; v.e_sl = sl; v.e_nl = nl;
    return v;
  endfunction

  typedef struct packed {
    logic [TI-1:0] w;
    logic          sl;
    logic          nl;
    logic          rep;
  } exp_t;

  vec_t          tbl [14];
  exp_t          expq [$];
  exp_t          e;
  logic [TI-1:0] vecq [$];
  logic [9:0]    got [$];
  logic [9:0]    st;
  logic [1:0]    q1 [$];
  logic [1:0]    w1;
  bit            stalled;
  bit            found;
  int            nvec, cyc, unl;

  initial begin
    do_reset();

    // Reset state
    chk("reset_state", {in_rdy, out_v, out_sf_last, out_nf_last, out}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});

    // Continuous streaming: one vector plus part of the next
    tbl[0]  = mk(8'h0, 1, 0, 8'h0, 0, 0);
    tbl[1]  = mk(8'h1, 1, 1, 8'h0, 0, 0);
    tbl[2]  = mk(8'h2, 1, 1, 8'h1, 0, 0);
    tbl[3]  = mk(8'h3, 1, 1, 8'h2, 0, 0);
    tbl[4]  = mk(8'h4, 0, 1, 8'h3, 1, 0);
    tbl[5]  = mk(8'h4, 0, 1, 8'h0, 0, 1);
    tbl[6]  = mk(8'h4, 0, 1, 8'h1, 0, 1);
    tbl[7]  = mk(8'h4, 0, 1, 8'h2, 0, 1);
    tbl[8]  = mk(8'h4, 1, 1, 8'h3, 1, 1);
    tbl[9]  = mk(8'h5, 1, 1, 8'h4, 0, 0);
    tbl[10] = mk(8'h6, 1, 1, 8'h5, 0, 0);
    tbl[11] = mk(8'h7, 1, 1, 8'h6, 0, 0);
    tbl[12] = mk(8'h8, 0, 1, 8'h7, 1, 0);
    tbl[13] = mk(8'h8, 0, 1, 8'h4, 0, 1);
    for (int i = 0; i < 14; i++) begin
      in_v = tbl[i].iv; in = tbl[i].d; out_rdy = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("stream_row%0d", i), {in_rdy, out_v, out_sf_last, out_nf_last, out},
          {tbl[i].e_irdy, tbl[i].e_ov, tbl[i].e_sl, tbl[i].e_nl, tbl[i].e_out});
      @(posedge clk); #1;
    end

    // Stall during replay with word 2 on out
    do_reset();
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_v = 1'b1; in = 8'(i);
      @(posedge clk); #1;
    end
    in_v = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (out_v && out == 8'h2 && out_nf_last) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("stall_found", found, 1);
    if (found) begin
      out_rdy = 1'b0;
      @(negedge clk);
      chk("stall_hold1", {out_v, out_sf_last, out_nf_last, out}, {1'b1, 1'b0, 1'b1, 8'h2});
      chk("stall_in_rdy", in_rdy, 0);
      @(negedge clk);
      chk("stall_hold2", {out_v, out_sf_last, out_nf_last, out}, {1'b1, 1'b0, 1'b1, 8'h2});
      out_rdy = 1'b1;
      @(negedge clk);
      chk("stall_next", {out_v, out_sf_last, out_nf_last, out}, {1'b1, 1'b1, 1'b1, 8'h3});
      @(negedge clk);
      chk("stall_drain", {in_rdy, out_v}, {1'b1, 1'b0});
      @(posedge clk); #1;
    end

    // in_v pulsed every third cycle during the first pass
    do_reset();
    out_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_v = (i % 3 == 0) && (i <= 9);
      in   = 8'(8'h10 + i / 3);
      @(negedge clk);
      chk($sformatf("pulse_in_rdy%0d", i), in_rdy, (i <= 9));
      chk($sformatf("pulse_out_v%0d", i), out_v, (i % 3 == 1) || (i == 11));
      if (i == 11)
        chk("pulse_replay", {out_sf_last, out_nf_last, out}, {1'b0, 1'b1, 8'h10});
      else if (i % 3 == 1)
        chk($sformatf("pulse_word%0d", i), {out_sf_last, out_nf_last, out},
            {(i == 10), 1'b0, 8'(8'h10 + (i - 1) / 3)});
      @(posedge clk); #1;
    end

    // Reset mid-vector aborts the partially received vector
    do_reset();
    out_rdy = 1'b1;
    in_v = 1'b1; in = 8'hA;
    @(posedge clk); #1;
    in = 8'hB;
    @(posedge clk); #1;
    in_v = 1'b0;
    chk("prerst_out", {out_v, out}, {1'b1, 8'hB});
    rst_n = 1'b0;
    #1;
    chk("async_rst", {out_v, out_sf_last, out_nf_last, out}, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    got.delete();
    for (int i = 0; i < 20; i++) begin
      in_v = (i < 4);
      in   = 8'(8'hC + i);
      @(negedge clk);
      if (out_v && out_rdy) got.push_back({out_sf_last, out_nf_last, out});
      @(posedge clk); #1;
    end
    in_v = 1'b0;
    chk("rst_count", got.size(), 8);
    for (int k = 0; k < 8 && k < got.size(); k++)
      chk($sformatf("rst_word%0d", k), got[k], {(k % 4 == 3), (k >= 4), 8'(8'hC + k % 4)});

    // SF=1, NF=1 instance with random handshakes
    do_reset();
    q1.delete();
    for (int i = 0; i < 80; i++) begin
      in_v1 = $urandom_range(1) != 0;
      in1 = 2'($urandom);
      out_rdy1 = $urandom_range(1) != 0;
      @(negedge clk);
      chk("nf1_in_rdy", in_rdy1, !out_v1 || out_rdy1);
      if (out_v1) begin
        chk("nf1_flags", {out_sf_last1, out_nf_last1}, 2'b11);
        if (out_rdy1) begin
          if (q1.size() == 0) chk("nf1_unexpected", 1, 0);
          else begin
            w1 = q1.pop_front();
            chk("nf1_word", out1, w1);
          end
        end
      end
      if (in_v1 && in_rdy1) q1.push_back(in1);
      @(posedge clk); #1;
    end
    in_v1 = 1'b0; out_rdy1 = 1'b0;

    // Random traffic on the main instance against the replay-stream model
    do_reset();
    expq.delete(); vecq.delete();
    nvec = 0; cyc = 0; stalled = 1'b0;
    while ((nvec < 1000 || expq.size() != 0) && cyc < 60000) begin
      in_v    = (nvec < 1000) && ($urandom_range(3) != 0);
      in      = 8'($urandom);
      out_rdy = $urandom_range(3) != 0;
      @(negedge clk);
      if (stalled)
        chk("rnd_stall_hold", {out_v, out_sf_last, out_nf_last, out}, {1'b1, st});
      unl = 0;
      foreach (expq[i]) if (expq[i].rep) unl++;
      if (out_v && expq.size() > 0 && expq[0].rep) unl--;
      chk("rnd_in_rdy", in_rdy, (unl == 0) && (!out_v || out_rdy));
      if (out_v) begin
        chk("rnd_no_x", $isunknown(out), 0);
        if (out_rdy) begin
          if (expq.size() == 0) chk("rnd_unexpected", 1, 0);
          else begin
            e = expq.pop_front();
            chk("rnd_word", {out_sf_last, out_nf_last, out}, {e.sl, e.nl, e.w});
          end
        end
      end
      stalled = out_v && !out_rdy;
      st = {out_sf_last, out_nf_last, out};
      if (in_v && in_rdy) begin
        expq.push_back('{w: in, sl: (vecq.size() == SF - 1), nl: (NF == 1), rep: 1'b0});
        vecq.push_back(in);
        if (vecq.size() == SF) begin
          for (int p = 1; p < NF; p++)
            for (int s = 0; s < SF; s++)
              expq.push_back('{w: vecq[s], sl: (s == SF - 1), nl: (p == NF - 1), rep: 1'b1});
          vecq.delete();
          nvec++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("rnd_complete", {nvec, expq.size()}, {32'd1000, 32'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
